// File: rtl/mod_counter_cascade.sv
// Modulo-MODULUS up/down counter with range-checked synchronous load, cascadable
// carry/borrow and a registered two-digit BCD copy of the count.
module mod_counter_cascade #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 24,
    parameter int START   = 0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Enable,
    input  logic             Cin,
    input  logic             Up,
    input  logic             LD,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] COUNT,
    output logic [3:0]       BCD_TENS,
    output logic [3:0]       BCD_ONES,
    output logic             Cout,
    output logic             LD_ERR
);

    localparam logic [WIDTH-1:0] TOP        = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] START_VAL  = WIDTH'(START);
    localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH + 1)'(MODULUS);
    localparam logic [3:0]       START_TENS = 4'(START / 10);
    localparam logic [3:0]       START_ONES = 4'(START % 10);

    logic             at_top;
    logic             at_zero;
    logic             load_ok;
    logic [WIDTH-1:0] next_count;
    logic             next_err;
    logic [3:0]       next_tens;
    logic [3:0]       next_ones;

    assign at_top  = (COUNT == TOP);
    assign at_zero = (COUNT == '0);
    // One extra bit so MODULUS == 2^WIDTH still compares correctly.
    assign load_ok = ({1'b0, IN} < MOD_EXT);

    assign Cout = Enable & Cin & ~LD & (Up ? at_top : at_zero);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        next_count = COUNT;
        next_err   = 1'b0;
        if (Enable && LD) begin
            if (load_ok) begin
                next_count = IN;
            end else begin
                next_err = 1'b1;
            end
        end else if (Enable && Cin) begin
            // Wrap is explicit so a MODULUS below 2^WIDTH never overflows into unused codes.
            if (Up) begin
                next_count = at_top ? '0 : COUNT + ONE;
            end else begin
                next_count = at_zero ? TOP : COUNT - ONE;
            end
        end
    end

    // BCD digits come from the next count so they land on the same edge as COUNT.
    always_comb begin
        next_tens = 4'(int'(next_count) / 10);
        next_ones = 4'(int'(next_count) % 10);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!Clr) begin
            COUNT    <= START_VAL;
            BCD_TENS <= START_TENS;
            BCD_ONES <= START_ONES;
            LD_ERR   <= 1'b0;
        end else begin
            COUNT    <= next_count;
            BCD_TENS <= next_tens;
            BCD_ONES <= next_ones;
            LD_ERR   <= next_err;
        end
    end

endmodule

// File: tb/tb_mod_counter_cascade.sv
// Directed bench for mod_counter_cascade: reset, wraps in both directions,
// load range checking, a seconds/hours cascade and asynchronous reset mid-count.
module tb_mod_counter_cascade;

    logic Clk;
    logic Clr;

    // Stage A: mod-24, START=7
    logic       en_a, cin_a, up_a, ld_a;
    logic [4:0] in_a, count_a;
    logic [3:0] tens_a, ones_a;
    logic       cout_a, err_a;

    // Stage B: mod-60, down-count tests
    logic       en_b, cin_b, up_b, ld_b;
    logic [5:0] in_b, count_b;
    logic [3:0] tens_b, ones_b;
    logic       cout_b, err_b;

    // Cascade: seconds (mod-60) feeding hours (mod-24)
    logic       cs_en, cs_up, cs_cin;
    logic       sec_ld, hr_ld;
    logic [5:0] sec_in, sec_count;
    logic [4:0] hr_in, hr_count;
    logic [3:0] sec_tens, sec_ones, hr_tens, hr_ones;
    logic       sec_cout, hr_cout, sec_err, hr_err;

    int n_cmp = 0;
    int n_err = 0;

    mod_counter_cascade #(.WIDTH(5), .MODULUS(24), .START(7)) dut_a (
        .Clk(Clk), .Clr(Clr), .Enable(en_a), .Cin(cin_a), .Up(up_a), .LD(ld_a),
        .IN(in_a), .COUNT(count_a), .BCD_TENS(tens_a), .BCD_ONES(ones_a),
        .Cout(cout_a), .LD_ERR(err_a)
    );

    mod_counter_cascade #(.WIDTH(6), .MODULUS(60), .START(0)) dut_b (
        .Clk(Clk), .Clr(Clr), .Enable(en_b), .Cin(cin_b), .Up(up_b), .LD(ld_b),
        .IN(in_b), .COUNT(count_b), .BCD_TENS(tens_b), .BCD_ONES(ones_b),
        .Cout(cout_b), .LD_ERR(err_b)
    );

    mod_counter_cascade #(.WIDTH(6), .MODULUS(60), .START(0)) dut_sec (
        .Clk(Clk), .Clr(Clr), .Enable(cs_en), .Cin(cs_cin), .Up(cs_up), .LD(sec_ld),
        .IN(sec_in), .COUNT(sec_count), .BCD_TENS(sec_tens), .BCD_ONES(sec_ones),
        .Cout(sec_cout), .LD_ERR(sec_err)
    );

    mod_counter_cascade #(.WIDTH(5), .MODULUS(24), .START(0)) dut_hr (
        .Clk(Clk), .Clr(Clr), .Enable(cs_en), .Cin(sec_cout), .Up(cs_up), .LD(hr_ld),
        .IN(hr_in), .COUNT(hr_count), .BCD_TENS(hr_tens), .BCD_ONES(hr_ones),
        .Cout(hr_cout), .LD_ERR(hr_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clr = 1'b1;
        en_a = 0; cin_a = 0; up_a = 1; ld_a = 0; in_a = '0;
        en_b = 0; cin_b = 0; up_b = 0; ld_b = 0; in_b = '0;
        cs_en = 0; cs_up = 1; cs_cin = 1; sec_ld = 0; hr_ld = 0; sec_in = '0; hr_in = '0;

        // Asynchronous reset before the first clock edge
        #2 Clr = 1'b0;
        #1;
        check("rst_count_a", count_a, 7);
        check("rst_tens_a", tens_a, 0);
        check("rst_ones_a", ones_a, 7);
        check("rst_err_a", err_a, 0);
        check("rst_count_b", count_b, 0);

        // No state change while Clr is held low
        en_a = 1; cin_a = 1; up_a = 1;
        step();
        check("rst_hold_a", count_a, 7);
        Clr = 1'b1;

        // Up-count wrap at 23 -> 0
        ld_a = 1; in_a = 5'd22;
        step();
        check("ld22_count", count_a, 22);
        check("ld22_tens", tens_a, 2);
        check("ld22_ones", ones_a, 2);
        ld_a = 0;
        #1;
        check("cout_at22", cout_a, 0);
        step();
        check("up_count23", count_a, 23);
        check("up_tens23", tens_a, 2);
        check("up_ones23", ones_a, 3);
        check("cout_at23", cout_a, 1);
        step();
        check("wrap_count0", count_a, 0);
        check("wrap_tens0", tens_a, 0);
        check("wrap_ones0", ones_a, 0);
        check("cout_at0_up", cout_a, 0);
        cin_a = 0;
        step();
        check("cin0_hold", count_a, 0);

        // Load range checking
        ld_a = 1; in_a = 5'd15;
        step();
        check("ld15_count", count_a, 15);
        check("ld15_err", err_a, 0);
        check("ld15_tens", tens_a, 1);
        check("ld15_ones", ones_a, 5);
        in_a = 5'd30;
        step();
        check("ld30_count", count_a, 15);
        check("ld30_err", err_a, 1);
        ld_a = 0; en_a = 0;
        step();
        check("err_pulse_clr", err_a, 0);
        check("idle_count", count_a, 15);
        ld_a = 1; in_a = 5'd3;
        step();
        check("ld_dis_count", count_a, 15);
        check("ld_dis_err", err_a, 0);
        en_a = 1; in_a = 5'd24;
        step();
        check("ld24_count", count_a, 15);
        check("ld24_err", err_a, 1);
        in_a = 5'd23;
        step();
        check("ld23_count", count_a, 23);
        check("ld23_err", err_a, 0);
        ld_a = 0; en_a = 0;

        // Down-count wrap on the mod-60 stage
        en_b = 1; ld_b = 1; in_b = 6'd1; up_b = 0; cin_b = 1;
        step();
        check("b_ld1", count_b, 1);
        ld_b = 0;
        #1;
        check("b_cout_at1", cout_b, 0);
        step();
        check("b_down0", count_b, 0);
        check("b_cout_at0", cout_b, 1);
        step();
        check("b_wrap59", count_b, 59);
        check("b_tens59", tens_b, 5);
        check("b_ones59", ones_b, 9);
        check("b_cout_at59", cout_b, 0);
        en_b = 0;

        // Cascade 23:59 -> 00:00
        cs_en = 1; sec_ld = 1; sec_in = 6'd59; hr_ld = 1; hr_in = 5'd23;
        step();
        check("cs_ld_sec", sec_count, 59);
        check("cs_ld_hr", hr_count, 23);
        sec_ld = 0; hr_ld = 0; cs_up = 1;
        #1;
        check("cs_sec_cout", sec_cout, 1);
        check("cs_hr_cout", hr_cout, 1);
        step();
        check("cs_sec_wrap", sec_count, 0);
        check("cs_hr_wrap", hr_count, 0);
        check("cs_hr_tens", hr_tens, 0);
        check("cs_hr_ones", hr_ones, 0);

        // Down-count borrow ripples the same way: 00:00 -> 23:59
        cs_up = 0;
        #1;
        check("cs_borrow", sec_cout, 1);
        step();
        check("cs_dn_sec", sec_count, 59);
        check("cs_dn_hr", hr_count, 23);
        check("cs_dn_hr_tens", hr_tens, 2);
        check("cs_dn_hr_ones", hr_ones, 3);

        // Load on the seconds stage kills its carry; hours must hold
        sec_ld = 1; sec_in = 6'd59;
        #1;
        check("cs_ld_cout", sec_cout, 0);
        check("cs_ld_hr_cout", hr_cout, 0);
        step();
        check("cs_ld_sec_hold", sec_count, 59);
        check("cs_ld_hr_hold", hr_count, 23);
        sec_ld = 0; cs_en = 0;

        // Asynchronous reset mid-count
        en_a = 1; ld_a = 1; in_a = 5'd10;
        step();
        check("ar_ld10", count_a, 10);
        ld_a = 0; cin_a = 1; up_a = 1;
        #3 Clr = 1'b0;
        #1;
        check("ar_count", count_a, 7);
        check("ar_tens", tens_a, 0);
        check("ar_ones", ones_a, 7);
        check("ar_err", err_a, 0);
        check("ar_sec", sec_count, 0);
        check("ar_hr", hr_count, 0);
        step();
        check("ar_held", count_a, 7);
        Clr = 1'b1;
        step();
        check("ar_resume", count_a, 8);
        check("ar_resume_ones", ones_a, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
